// File: rtl/load_scoreboard_pkg.sv
// Shared types for the load scoreboard: register index, decoded issue request
// and the default load-queue depth.
package load_scoreboard_pkg;

    localparam int LQ_DEPTH_DEFAULT = 4;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     use_rs1;
        logic     use_rs2;
        logic     regw;
        logic     memr;
    } issue_req_t;

endpackage

// File: rtl/load_scoreboard_ld_dest_fifo.sv
// In-order FIFO of load destination registers; the head is the register that
// the next load response will write.
module ld_dest_fifo
    import load_scoreboard_pkg::*;
#(
    parameter int DEPTH = LQ_DEPTH_DEFAULT,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  reg_idx_t      push_idx,
    input  logic          pop,
    output reg_idx_t      head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    reg_idx_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/load_scoreboard.sv
// Issue-side hazard controller: stalls decode on RAW/WAW against loads in flight
// and arbitrates the register-file write port between load responses and the ALU.
module load_scoreboard
    import load_scoreboard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT,
    parameter int XLEN     = 32,
    localparam int CW = $clog2(LQ_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_regw,
    input  logic            id_memr,
    output logic            id_stall,
    output logic            id_issue,
    input  logic            alu_wb_valid,
    input  logic [4:0]      alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            ld_rsp_valid,
    input  logic [XLEN-1:0] ld_rsp_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [CW-1:0]   lq_count,
    output logic            err_orphan_rsp
);

    issue_req_t      req;
    logic [NREG-1:0] pending;
    reg_idx_t        head;
    logic            lq_full;
    logic            lq_empty;
    logic            load_issue;
    logic            rsp_hit;
    logic            raw1;
    logic            raw2;
    logic            waw;

    assign req = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd, use_rs1: id_use_rs1,
                   use_rs2: id_use_rs2, regw: id_regw, memr: id_memr};

    // Hazards look only at registered state: a response clearing a register
    // this cycle still stalls its dependent for one more cycle.
    assign raw1 = req.use_rs1 && (req.rs1 != '0) && pending[req.rs1];
    assign raw2 = req.use_rs2 && (req.rs2 != '0) && pending[req.rs2];
    assign waw  = req.regw && (req.rd != '0) && pending[req.rd];

    assign id_stall   = id_valid && (raw1 || raw2 || waw || (req.memr && req.regw && lq_full));
    assign id_issue   = id_valid && !id_stall;
    assign load_issue = id_issue && req.memr && req.regw;
    assign rsp_hit    = ld_rsp_valid && !lq_empty;

    // Loads to x0 still enter the queue so responses stay matched in order.
    ld_dest_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (load_issue),
        .push_idx (req.rd),
        .pop      (rsp_hit),
        .head     (head),
        .count    (lq_count),
        .full     (lq_full),
        .empty    (lq_empty)
    );

    // A set from a new load is applied after the clear so it wins on the same index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (rsp_hit) begin
                pending[head] <= 1'b0;
            end
            if (load_issue && (req.rd != '0)) begin
                pending[req.rd] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_orphan_rsp <= 1'b0;
        end else if (ld_rsp_valid && lq_empty) begin
            err_orphan_rsp <= 1'b1;
        end
    end

    // Load responses cannot be back-pressured, so they always own the write port.
    always_comb begin
        alu_wb_ready = !rsp_hit;
        rf_we        = 1'b0;
        rf_waddr     = alu_wb_rd;
        rf_wdata     = alu_wb_data;
        if (rsp_hit) begin
            rf_we    = (head != '0);
            rf_waddr = head;
            rf_wdata = ld_rsp_data;
        end else begin
            rf_we    = alu_wb_valid && (alu_wb_rd != '0);
        end
    end

endmodule

// File: tb/tb_load_scoreboard.sv
// Self-checking bench for load_scoreboard: directed scenarios followed by random
// traffic, all checked against a queue-based model of loads in flight.
module tb_load_scoreboard;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_regw;
    logic        id_memr;
    logic        id_stall;
    logic        id_issue;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  lq_count;
    logic        err_orphan_rsp;

    int nVec  = 0;
    int nFail = 0;

    // Model: destinations of loads in flight, oldest first, plus the orphan flag.
    int loadQ[$];
    bit errModel;

    load_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_rd          (id_rd),
        .id_regw        (id_regw),
        .id_memr        (id_memr),
        .id_stall       (id_stall),
        .id_issue       (id_issue),
        .alu_wb_valid   (alu_wb_valid),
        .alu_wb_rd      (alu_wb_rd),
        .alu_wb_data    (alu_wb_data),
        .alu_wb_ready   (alu_wb_ready),
        .ld_rsp_valid   (ld_rsp_valid),
        .ld_rsp_data    (ld_rsp_data),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .lq_count       (lq_count),
        .err_orphan_rsp (err_orphan_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit inFlight(input int r);
        if (r == 0) return 1'b0;
        foreach (loadQ[i]) begin
            if (loadQ[i] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit modelStall();
        return id_valid && ((id_use_rs1 && inFlight(int'(id_rs1))) ||
                            (id_use_rs2 && inFlight(int'(id_rs2))) ||
                            (id_regw && inFlight(int'(id_rd))) ||
                            (id_memr && id_regw && loadQ.size() == 4));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        assert (got === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkOutput();
        bit hit;
        bit expWe;
        int expAddr;
        logic [31:0] expData;
        hit = ld_rsp_valid && loadQ.size() > 0;
        if (hit) begin
            expWe   = (loadQ[0] != 0);
            expAddr = loadQ[0];
            expData = ld_rsp_data;
        end else begin
            expWe   = alu_wb_valid && (alu_wb_rd != 0);
            expAddr = int'(alu_wb_rd);
            expData = alu_wb_data;
        end
        chk("id_stall", 32'(id_stall), 32'(modelStall()));
        chk("id_issue", 32'(id_issue), 32'(id_valid && !modelStall()));
        chk("alu_wb_ready", 32'(alu_wb_ready), 32'(!hit));
        chk("rf_we", 32'(rf_we), 32'(expWe));
        if (expWe) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(expAddr));
            chk("rf_wdata", rf_wdata, expData);
        end
        chk("lq_count", 32'(lq_count), 32'(loadQ.size()));
        chk("err_orphan_rsp", 32'(err_orphan_rsp), 32'(errModel));
    endtask

    // Sets inputs at the falling edge, checks them, then advances the model across the rising edge.
    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic av,
                                 input logic [4:0] ard, input logic [31:0] ad,
                                 input logic rv, input logic [31:0] rdat);
        bit issueLoad;
        bit hit;
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_regw = rw; id_memr = mr;
        alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = ad;
        ld_rsp_valid = rv; ld_rsp_data = rdat;
        #1;
        checkOutput();
        issueLoad = id_valid && !modelStall() && id_memr && id_regw;
        hit = ld_rsp_valid && loadQ.size() > 0;
        if (ld_rsp_valid && loadQ.size() == 0) errModel = 1'b1;
        @(posedge clk);
        if (hit) void'(loadQ.pop_front());
        if (issueLoad) loadQ.push_back(int'(rd));
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic loadTo(input logic [4:0] rd);
        applyStimulus(1, 0, 1, 0, 0, rd, 1, 1, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        loadQ.delete();
        errModel = 1'b0;
        checkOutput();
        #2;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_regw = 0; id_memr = 0;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        ld_rsp_valid = 0; ld_rsp_data = 0;
        errModel = 1'b0;
        @(negedge clk);
        doReset();

        // lw x5, then add x6,x5,x1 stalls until the response, then issues.
        loadTo(5);
        applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 32'h0, 1, 32'hDEADBEEF);
        chk("dep_issue_after_rsp_pre", 32'(loadQ.size()), 32'd0);
        applyStimulus(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 32'h0, 0, 32'h0);

        // Fill the queue, the fifth load stalls until one slot frees.
        loadTo(1); loadTo(2); loadTo(3); loadTo(4);
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 32'h0, 1, 32'h11111111);
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 32'h0, 0, 32'h0);

        // Load response collides with ALU writeback to x7; ALU writes next cycle.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h1234, 1, 32'h22222222);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h1234, 0, 32'h0);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h33333333);

        // lw x0: no pending, no write, count returns to zero.
        loadTo(0);
        applyStimulus(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 32'h0, 1, 32'h44444444);
        idle();

        // Orphan response: sticky until reset.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h55555555);
        idle(); idle();

        // Reset mid-flight drops two loads; a stale response is then an orphan.
        doReset();
        loadTo(10); loadTo(11);
        applyStimulus(1, 10, 1, 11, 1, 12, 1, 0, 0, 0, 32'h0, 0, 32'h0);
        doReset();
        applyStimulus(1, 10, 1, 11, 1, 12, 1, 0, 0, 0, 32'h0, 1, 32'h66666666);
        idle();
        doReset();

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            logic rv;
            if (i == 200) doReset();
            rv = (loadQ.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
            applyStimulus($urandom_range(0, 3) != 0,
                          5'($urandom_range(0, 7)), 1'($urandom),
                          5'($urandom_range(0, 7)), 1'($urandom),
                          5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) == 0,
                          1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                          rv, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
